// File: rtl/weight_pkg.sv
// Shared types and index-width helpers for the weight loader and its read-side counterpart.
package weight_pkg;

    localparam int unsigned WL_COLS   = 3;
    localparam int unsigned WL_ROWS   = 3;
    localparam int unsigned WL_DATA_W = 8;

    // Index width for a count of n elements, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned WL_COL_W = idx_width(WL_COLS);
    localparam int unsigned WL_ROW_W = idx_width(WL_ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } wl_state_e;

    typedef struct packed {
        logic [WL_ROW_W-1:0]  row;
        logic [WL_COL_W-1:0]  col;
        logic [WL_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wl_index_counter.sv
// Row-major row/column wrap counter; last_c flags the final element of the tile.
module wl_index_counter
    import weight_pkg::*;
#(
    parameter int unsigned COLS  = WL_COLS,
    parameter int unsigned ROWS  = WL_ROWS,
    parameter int unsigned COL_W = idx_width(COLS),
    parameter int unsigned ROW_W = idx_width(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last_c
);

    logic col_last_c;
    logic row_last_c;

    assign col_last_c = (col == COL_W'(COLS - 1));
    assign row_last_c = (row == ROW_W'(ROWS - 1));
    assign last_c     = col_last_c & row_last_c;

    // Column wraps into the next row; the final element wraps the whole tile to (0,0).
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_last_c) begin
                col <= '0;
                row <= row_last_c ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Streams weight words into the weight buffer in row-major order and hands the full tile to the reader.
// Optional per-tile checksum output enabled by defining WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader
    import weight_pkg::*;
#(
    parameter int unsigned WEIGHT_COLS = WL_COLS,
    parameter int unsigned WEIGHT_ROWS = WL_ROWS,
    parameter int unsigned DATA_WIDTH  = WL_DATA_W,
    parameter int unsigned COL_W       = idx_width(WEIGHT_COLS),
    parameter int unsigned ROW_W       = idx_width(WEIGHT_ROWS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ROW_W-1:0]      wr_row,
    output logic [COL_W-1:0]      wr_col,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  weights_ready,
    input  logic                  weights_consumed,
    output logic                  busy
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]           checksum
`endif
);

    wl_state_e        state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             last_c;
    logic             transfer_c;
    logic             start_c;

    assign transfer_c = in_valid & in_ready & (state == LOAD);
    assign start_c    = load_start & (state == IDLE);

    wl_index_counter #(
        .COLS  (WEIGHT_COLS),
        .ROWS  (WEIGHT_ROWS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_index (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_c),
        .advance (transfer_c),
        .row     (row),
        .col     (col),
        .last_c  (last_c)
    );

    // Control FSM; in_ready drops on the final transfer so no extra word slips in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            wr_en         <= 1'b0;
            wr_row        <= '0;
            wr_col        <= '0;
            wr_data       <= '0;
            weights_ready <= 1'b0;
            busy          <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (transfer_c) begin
                        wr_en   <= 1'b1;
                        wr_row  <= row;
                        wr_col  <= col;
                        wr_data <= in_data;
                        if (last_c) begin
                            state    <= FULL;
                            in_ready <= 1'b0;
                        end
                    end
                end
                FULL: begin
                    // A start arriving with consume is dropped; the requester must re-issue.
                    if (weights_consumed) begin
                        state         <= IDLE;
                        weights_ready <= 1'b0;
                        busy          <= 1'b0;
                    end else begin
                        weights_ready <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    in_ready      <= 1'b0;
                    weights_ready <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    // Running modulo-2^16 sum of accepted words, restarted with each tile.
    always_ff @(posedge clk) begin
        if (reset || start_c) begin
            checksum <= '0;
        end else if (transfer_c) begin
            checksum <= checksum + 16'(in_data);
        end
    end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: tile-level behavioural model plus directed literal checks.
module tb_weight_loader;

    localparam int unsigned COLS  = 3;
    localparam int unsigned ROWS  = 3;
    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 2;
    localparam int unsigned RW    = 2;
    localparam int unsigned TILE  = COLS * ROWS;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_FULL = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          weights_consumed = 1'b0;
    logic          in_ready;
    logic          wr_en;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic [DW-1:0] wr_data;
    logic          weights_ready;
    logic          busy;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    weight_loader dut (
        .clk              (clk),
        .reset            (reset),
        .load_start       (load_start),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .wr_en            (wr_en),
        .wr_row           (wr_row),
        .wr_col           (wr_col),
        .wr_data          (wr_data),
        .weights_ready    (weights_ready),
        .weights_consumed (weights_consumed),
        .busy             (busy)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        ,
        .checksum         (checksum)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks the tile as a word count and derives addresses arithmetically.
    int          m_mode = M_IDLE;
    int          m_count = 0;
    int          m_sum = 0;
    logic        e_in_ready = 1'b0;
    logic        e_wr_en = 1'b0;
    int          e_row = 0;
    int          e_col = 0;
    int          e_data = 0;
    logic        e_wready = 1'b0;
    logic        e_busy = 1'b0;

    always @(posedge clk) begin
        int prev;
        prev    = m_mode;
        e_wr_en = 1'b0;
        if (reset) begin
            m_mode  = M_IDLE;
            m_count = 0;
            m_sum   = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (load_start) begin
                    m_mode  = M_LOAD;
                    m_count = 0;
                    m_sum   = 0;
                end
                M_LOAD: if (in_valid) begin
                    e_wr_en = 1'b1;
                    e_row   = m_count / COLS;
                    e_col   = m_count % COLS;
                    e_data  = int'(in_data);
                    m_sum   = (m_sum + int'(in_data)) % 65536;
                    m_count++;
                    if (m_count == TILE) begin
                        m_mode  = M_FULL;
                        m_count = 0;
                    end
                end
                default: if (weights_consumed) m_mode = M_IDLE;
            endcase
        end
        e_in_ready = (m_mode == M_LOAD);
        e_busy     = (m_mode != M_IDLE);
        e_wready   = !reset && (prev == M_FULL) && (m_mode == M_FULL);
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(e_in_ready));
        chk("wr_en", 32'(wr_en), 32'(e_wr_en));
        if (e_wr_en) begin
            chk("wr_row", 32'(wr_row), 32'(e_row));
            chk("wr_col", 32'(wr_col), 32'(e_col));
            chk("wr_data", 32'(wr_data), 32'(e_data));
        end
        chk("weights_ready", 32'(weights_ready), 32'(e_wready));
        chk("busy", 32'(busy), 32'(e_busy));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        if (e_wready) chk("checksum", 32'(checksum), 32'(m_sum));
`endif
    end

    // Log of observed buffer writes for the literal checks.
    int          wn = 0;
    int          log_row [$];
    int          log_col [$];
    int          log_data[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wn++;
            log_row.push_back(int'(wr_row));
            log_col.push_back(int'(wr_col));
            log_data.push_back(int'(wr_data));
        end
    end

    task automatic clear_log();
        wn = 0;
        log_row.delete();
        log_col.delete();
        log_data.delete();
    endtask

    task automatic cyc(input logic rst, input logic ls, input logic v, input logic [DW-1:0] d,
                       input logic wc);
        @(negedge clk);
        reset            = rst;
        load_start       = ls;
        in_valid         = v;
        in_data          = d;
        weights_consumed = wc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic chk_write(input string name, input int idx, input int r, input int c, input int d);
        if (idx >= wn) begin
            chk({name, "_present"}, 32'(wn), 32'(idx + 1));
        end else begin
            chk({name, "_row"}, 32'(log_row[idx]), 32'(r));
            chk({name, "_col"}, 32'(log_col[idx]), 32'(c));
            chk({name, "_data"}, 32'(log_data[idx]), 32'(d));
        end
    endtask

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_wr_addr", 32'({wr_row, wr_col}), 32'd0);
        chk("reset_wr_data", 32'(wr_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Back-to-back tile 0x01..0x09
        clear_log();
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 9; i++) cyc(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("b2b_ninth_strobe", 32'(wr_en), 32'd1);
        chk("b2b_wready_not_yet", 32'(weights_ready), 32'd0);
        chk("b2b_in_ready_low", 32'(in_ready), 32'd0);
        idle(1);
        #1;
        chk("b2b_wready_rise", 32'(weights_ready), 32'd1);
        chk("b2b_writes", 32'(wn), 32'd9);
        chk_write("b2b_w0", 0, 0, 0, 1);
        chk_write("b2b_w3", 3, 1, 0, 4);
        chk_write("b2b_w8", 8, 2, 2, 9);

        // Held-off input while FULL
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        #1;
        chk("full_no_writes", 32'(wn), 32'd9);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("consumed_wready", 32'(weights_ready), 32'd0);
        chk("consumed_busy", 32'(busy), 32'd0);

        // Gapped stream, in_valid every other cycle
        clear_log();
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 8'hAA, 1'b0);
        end
        idle(3);
        #1;
        chk("gap_writes", 32'(wn), 32'd9);
        chk_write("gap_w5", 5, 1, 2, 8'h26);
        chk_write("gap_w6", 6, 2, 0, 8'h27);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(2);

        // Reset after the 4th word, then restart from (0,0)
        clear_log();
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h56, 1'b0);
        #1;
        chk("midreset_wr_en", 32'(wr_en), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd0);
        chk("midreset_addr", 32'({wr_row, wr_col}), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_writes", 32'(wn), 32'd4);
        idle(1);
        clear_log();
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 9; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        idle(2);
        chk_write("restart_w0", 0, 0, 0, 8'h61);
        chk("restart_writes", 32'(wn), 32'd9);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(1);

        // load_start during LOAD ignored; start with consume in FULL dropped
        clear_log();
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 9; i++) cyc(1'b0, (i == 5), 1'b1, 8'(8'h80 + i), 1'b0);
        idle(3);
        #1;
        chk("midstart_writes", 32'(wn), 32'd9);
        chk_write("midstart_w4", 4, 1, 1, 8'h85);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        idle(3);
        #1;
        chk("drop_start_busy", 32'(busy), 32'd0);
        chk("drop_start_in_ready", 32'(in_ready), 32'd0);
        chk("drop_start_wready", 32'(weights_ready), 32'd0);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        idle(3);
        #1;
        chk("checksum_ff", 32'(checksum), 32'h08F7);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(1);
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
